average_pooling: RTL and testbench

- Memory-resident 2-D average-pooling accelerator for the RISC-V custom-instruction datapath.
- Holds an internal word-addressed scratchpad of 2^ADDR_WIDTH x DATA_WIDTH.
- On start, reads a square DxD unsigned matrix from `input_addr`, averages every PxP window placed with stride S, and writes the OxO result matrix to `output_addr`.
- Signals completion with a one-cycle `valid_out` pulse.

---
 rtl/average_pooling.sv | 191 +++++++++++++++++++
 tb/tb_average_pooling.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/average_pooling.sv
// -----------------------------------------------------------------------------
// average_pooling
//   2-D average-pooling engine with an internal word-addressed scratchpad.
//   On a start request it reads a DxD unsigned matrix from input_addr. It
//   averages every PxP window placed with stride S, using a truncating divide,
//   and writes the OxO result matrix row-major to output_addr. The output edge
//   is O = floor((D-P)/S)+1. Completion is flagged by a one-cycle valid_out
//   pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   valid_in     start request, level-sampled while idle
//   pool_size    P, window edge length
//   stride       S, window step for rows and columns
//   input_addr   base word address of the input matrix (row-major)
//   output_addr  base word address of the output matrix (row-major)
//   dimensions   D, input matrix edge length
//   valid_out    one-cycle done pulse
//
// The scratchpad array `mem` has a combinational read and a synchronous write.
// It is not cleared by reset.
// -----------------------------------------------------------------------------
module average_pooling #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DIM_WIDTH-1:0]  pool_size,
    input  logic [DIM_WIDTH-1:0]  stride,
    input  logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [ADDR_WIDTH-1:0] output_addr,
    input  logic [DIM_WIDTH-1:0]  dimensions,
    output logic                  valid_out
);

    localparam int ACC_W  = DATA_WIDTH + 2*DIM_WIDTH;
    localparam int AREA_W = 2*DIM_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Latched operation configuration
    logic [DIM_WIDTH-1:0]  p_r, s_r, d_r;
    logic [ADDR_WIDTH-1:0] in_base, out_base;

    // Window position (win_*) and element position inside the window (el_*)
    logic [DIM_WIDTH-1:0]  win_r, win_c, el_r, el_c;
    logic [ACC_W-1:0]      acc;

    logic                  cfg_bad;
    logic [DIM_WIDTH-1:0]  s_safe;
    logic [DIM_WIDTH-1:0]  o_edge;
    logic                  last_elem, last_win;
    logic [ADDR_WIDTH-1:0] rd_row, rd_col, rd_addr, wr_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [AREA_W-1:0]     area;
    logic [DATA_WIDTH-1:0] avg;

    // Truncating unsigned mean. The quotient never exceeds the largest element,
    // so keeping the low DATA_WIDTH bits is exact.
    function automatic logic [DATA_WIDTH-1:0] trunc_avg(
        input logic [ACC_W-1:0]  sum,
        input logic [AREA_W-1:0] n
    );
        logic [ACC_W-1:0] q;
        q = sum / ACC_W'(n);
        return q[DATA_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Combinational datapath: addressing, window bookkeeping, divide
    // ------------------------------------------------------------------
    always_comb begin
        cfg_bad   = (p_r == '0) || (s_r == '0) || (d_r == '0) || (p_r > d_r);
        // s_safe only keeps the divider defined while the config is bad.
        // The result is unused in that case.
        s_safe    = (s_r == '0) ? DIM_WIDTH'(1) : s_r;
        o_edge    = ((d_r - p_r) / s_safe) + DIM_WIDTH'(1);
        last_elem = (el_r == p_r - DIM_WIDTH'(1)) && (el_c == p_r - DIM_WIDTH'(1));
        last_win  = (win_r == o_edge - DIM_WIDTH'(1)) && (win_c == o_edge - DIM_WIDTH'(1));
        // All address terms wrap modulo 2^ADDR_WIDTH
        rd_row    = ADDR_WIDTH'(win_r) * ADDR_WIDTH'(s_r) + ADDR_WIDTH'(el_r);
        rd_col    = ADDR_WIDTH'(win_c) * ADDR_WIDTH'(s_r) + ADDR_WIDTH'(el_c);
        rd_addr   = in_base + rd_row * ADDR_WIDTH'(d_r) + rd_col;
        wr_addr   = out_base + ADDR_WIDTH'(win_r) * ADDR_WIDTH'(o_edge) + ADDR_WIDTH'(win_c);
        area      = (p_r == '0) ? AREA_W'(1) : AREA_W'(p_r) * AREA_W'(p_r);
        avg       = trunc_avg(acc, area);
    end

    assign rd_data = mem[rd_addr];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Every start goes through ACCUM. A bad latched config leaves ACCUM on
    // its first cycle without reading, so it never produces a write.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (valid_in) next_state = ACCUM;
            ACCUM:   if (cfg_bad) next_state = DONE;
                     else if (last_elem) next_state = WRITE;
            WRITE:   next_state = last_win ? DONE : ACCUM;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration latch, counters, accumulator, done flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_r       <= '0;
            s_r       <= '0;
            d_r       <= '0;
            in_base   <= '0;
            out_base  <= '0;
            win_r     <= '0;
            win_c     <= '0;
            el_r      <= '0;
            el_c      <= '0;
            acc       <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= (next_state == DONE);
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        p_r      <= pool_size;
                        s_r      <= stride;
                        d_r      <= dimensions;
                        in_base  <= input_addr;
                        out_base <= output_addr;
                        win_r    <= '0;
                        win_c    <= '0;
                        el_r     <= '0;
                        el_c     <= '0;
                        acc      <= '0;
                    end
                end
                ACCUM: begin
                    if (!cfg_bad) begin
                        acc <= acc + ACC_W'(rd_data);
                        if (el_c == p_r - DIM_WIDTH'(1)) begin
                            el_c <= '0;
                            el_r <= last_elem ? '0 : el_r + DIM_WIDTH'(1);
                        end else begin
                            el_c <= el_c + DIM_WIDTH'(1);
                        end
                    end
                end
                WRITE: begin
                    acc <= '0;
                    if (win_c == o_edge - DIM_WIDTH'(1)) begin
                        win_c <= '0;
                        win_r <= win_r + DIM_WIDTH'(1);
                    end else begin
                        win_c <= win_c + DIM_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scratchpad write port (no reset: contents survive an abort)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == WRITE) mem[wr_addr] <= avg;
    end

endmodule

// File: tb/tb_average_pooling.sv
module tb_average_pooling;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [3:0]  pool_size, stride, dimensions;
    logic [11:0] input_addr, output_addr;
    logic        valid_out;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [0:4095];

    average_pooling #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DIM_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .pool_size   (pool_size),
        .stride      (stride),
        .input_addr  (input_addr),
        .output_addr (output_addr),
        .dimensions  (dimensions),
        .valid_out   (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input logic [31:0] v);
        logic [11:0] a12;
        a12 = a[11:0];
        dut.mem[a12]   = v;
        model_mem[a12] = v;
    endtask

    // Reference model: computes expected outputs from the shadow memory and
    // queues them for comparison once the DUT reports done
    task automatic model_pool(input int p, input int s, input int d, input int ia, input int oa);
        int o;
        longint sum;
        logic [31:0] q;
        logic [11:0] a;
        o = (d - p) / s + 1;
        for (int r = 0; r < o; r++) begin
            for (int c = 0; c < o; c++) begin
                sum = 0;
                for (int i = 0; i < p; i++)
                    for (int j = 0; j < p; j++)
                        sum += longint'(model_mem[(ia + (r*s + i)*d + c*s + j) & 32'hFFF]);
                q = 32'(sum / (p*p));
                a = 12'((oa + r*o + c) & 32'hFFF);
                model_mem[a] = q;
                sb.push_back('{addr: a, data: q});
            end
        end
    endtask

    // Drives the config for one cycle around the accepting edge (edge 0)
    task automatic start(input int p, input int s, input int d, input int ia, input int oa);
        @(negedge clk);
        pool_size   = 4'(p);
        stride      = 4'(s);
        dimensions  = 4'(d);
        input_addr  = 12'(ia);
        output_addr = 12'(oa);
        valid_in    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Counts edges after the accepting edge until valid_out is seen high
    task automatic wait_done(input string tag, input int exp_edge);
        int seen_at;
        seen_at = -1;
        for (int k = 1; k <= exp_edge + 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_out) begin
                seen_at = k;
                break;
            end
        end
        check({tag, "_latency"}, 64'(seen_at), 64'(exp_edge));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pulse_end"}, 64'(valid_out), 64'd0);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_mem"}, 64'(dut.mem[e.addr]), 64'(e.data));
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b0;
        valid_in    = 1'b0;
        pool_size   = '0;
        stride      = '0;
        dimensions  = '0;
        input_addr  = '0;
        output_addr = '0;
        for (int i = 0; i < 4096; i++) poke(i, 32'd0);
        for (int i = 0; i < 16; i++) poke(i, 32'(i));

        // Reset state
        #12;
        check("reset_valid_out", 64'(valid_out), 64'd0);
        check("reset_state", 64'(dut.state), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Stride-2 pooling
        model_pool(2, 2, 4, 'h000, 'h100);
        start(2, 2, 4, 'h000, 'h100);
        wait_done("s2", 20);
        check("s2_0x100", 64'(dut.mem[12'h100]), 64'd2);
        check("s2_0x101", 64'(dut.mem[12'h101]), 64'd4);
        check("s2_0x102", 64'(dut.mem[12'h102]), 64'd10);
        check("s2_0x103", 64'(dut.mem[12'h103]), 64'd12);
        drain("s2");

        // Stride-1 pooling
        model_pool(2, 1, 4, 'h000, 'h200);
        start(2, 1, 4, 'h000, 'h200);
        wait_done("s1", 45);
        check("s1_0x200", 64'(dut.mem[12'h200]), 64'd2);
        check("s1_0x204", 64'(dut.mem[12'h204]), 64'd7);
        check("s1_0x208", 64'(dut.mem[12'h208]), 64'd12);
        drain("s1");

        // Truncating divide: 38/9
        for (int i = 0; i < 8; i++) poke('h10 + i, 32'(i));
        poke('h18, 32'd10);
        model_pool(3, 2, 3, 'h010, 'h300);
        start(3, 2, 3, 'h010, 'h300);
        wait_done("trunc", 10);
        check("trunc_0x300", 64'(dut.mem[12'h300]), 64'd4);
        drain("trunc");

        // Invalid config with valid_in held high: pulses after edges 1, 4, 7
        poke('h500, 32'hCAFE_F00D);
        @(negedge clk);
        pool_size   = 4'd5;
        stride      = 4'd1;
        dimensions  = 4'd4;
        input_addr  = 12'h000;
        output_addr = 12'h500;
        valid_in    = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("inv_edge%0d", k), 64'(valid_out), 64'((k % 3) == 1));
        end
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check("inv_no_write", 64'(dut.mem[12'h500]), 64'hCAFE_F00D);
        check("inv_idle", 64'(dut.state), 64'd0);

        // Reset in the middle of the stride-1 case
        for (int i = 0; i < 9; i++) poke('h200 + i, 32'hDEAD_BEEF);
        start(2, 1, 4, 'h000, 'h200);
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_state", 64'(dut.state), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_valid_out", 64'(valid_out), 64'd0);
        end
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rst_after_valid_out", 64'(valid_out), 64'd0);
        end
        check("rst_after_state", 64'(dut.state), 64'd0);
        check("rst_0x200_written", 64'(dut.mem[12'h200]), 64'd2);
        check("rst_0x201_kept", 64'(dut.mem[12'h201]), 64'hDEAD_BEEF);

        // Address wrap past the top of memory
        poke('hFFE, 32'd4);
        poke('hFFF, 32'd8);
        poke('h000, 32'd12);
        poke('h001, 32'd16);
        model_pool(2, 1, 2, 'hFFE, 'h400);
        start(2, 1, 2, 'hFFE, 'h400);
        wait_done("wrap", 5);
        check("wrap_0x400", 64'(dut.mem[12'h400]), 64'd10);
        drain("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
